// File: rtl/game_pkg.sv
// Shared constants for the countdown-timer game round sequencer: state encoding,
// count width and default 50 MHz tick counts.
package game_pkg;
  localparam int CNT_W = 8;

  localparam int unsigned DEF_READY_TICKS   = 150_000_000;
  localparam int unsigned DEF_HIT_TARGET    = 20;
  localparam int unsigned DEF_HOLDOFF_TICKS = 25_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_e;
endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for the raw start button plus a registered rising-edge pulse.
// The pulse is high 3 cycles after the button input rises.
module btn_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic rise
);
  // [0],[1] synchroniser stages, [2] previous synchronised level
  logic [2:0] sync_q, sync_d;
  logic       rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn_in};
    rise_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;
endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: IDLE -> READY countdown -> PLAY -> WIN/LOSE, driving the timer block.
// Define MISS_HOLDOFF_EN to suppress repeated misses for HOLDOFF_TICKS cycles.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned READY_TICKS   = DEF_READY_TICKS,
  parameter int unsigned HIT_TARGET    = DEF_HIT_TARGET,
  parameter int unsigned HOLDOFF_TICKS = DEF_HOLDOFF_TICKS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             hit,
  input  logic             miss_in,
  input  logic             game_over,
  output logic             timer_start,
  output logic             timer_miss,
  output logic             timer_game_end,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             led_win,
  output logic             led_lose
);
  localparam logic [31:0]      READY_LOAD = 32'(READY_TICKS - 1);
  localparam logic [CNT_W-1:0] HIT_TGT    = CNT_W'(HIT_TARGET);

  state_e           state_q, state_d;
  logic [31:0]      ready_cnt_q, ready_cnt_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d, hit_inc;
  logic             tstart_q, tstart_d, tmiss_q, tmiss_d, tend_q, tend_d;
  logic             lwin_q, lwin_d, llose_q, llose_d;
  logic             start_edge, miss_ok;

  btn_edge_sync u_btn_sync (
    .clock  (clock),
    .reset  (reset),
    .btn_in (btn_start),
    .rise   (start_edge)
  );

`ifdef MISS_HOLDOFF_EN
  localparam logic [31:0] HOLD_LOAD = 32'(HOLDOFF_TICKS - 1);
  logic [31:0] hold_q, hold_d;

  // Window clears while counting down in READY, so PLAY always starts open.
  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_READY) hold_d = '0;
    else if (state_q == ST_PLAY) begin
      if (miss_in && hold_q == '0) hold_d = HOLD_LOAD;
      else if (hold_q != '0)       hold_d = hold_q - 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign miss_ok = (hold_q == '0);
`else
  logic unused_holdoff;
  assign unused_holdoff = |HOLDOFF_TICKS;
  assign miss_ok        = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    ready_cnt_d = ready_cnt_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    tstart_d    = 1'b0;
    tmiss_d     = 1'b0;
    tend_d      = tend_q;
    hit_inc     = hit_q + 8'd1;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d     = ST_READY;
          ready_cnt_d = READY_LOAD;
        end
      end
      ST_READY: begin
        if (ready_cnt_q == '0) begin
          state_d  = ST_PLAY;
          tstart_d = 1'b1;
        end else begin
          ready_cnt_d = ready_cnt_q - 32'd1;
        end
      end
      ST_PLAY: begin
        if (hit) begin
          hit_d = hit_inc;
          if (hit_inc == HIT_TGT) begin
            state_d = ST_WIN;
            tend_d  = 1'b1;
          end
        end
        // Time-out beats a same-cycle winning hit; the timer is not frozen.
        if (game_over) begin
          state_d = ST_LOSE;
          tend_d  = 1'b0;
        end
        if (miss_in && miss_ok) begin
          tmiss_d = 1'b1;
          if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
        end
      end
      default: ;
    endcase
    lwin_d  = (state_d == ST_WIN);
    llose_d = (state_d == ST_LOSE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_cnt_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      tstart_q    <= 1'b0;
      tmiss_q     <= 1'b0;
      tend_q      <= 1'b0;
      lwin_q      <= 1'b0;
      llose_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_cnt_q <= ready_cnt_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      tstart_q    <= tstart_d;
      tmiss_q     <= tmiss_d;
      tend_q      <= tend_d;
      lwin_q      <= lwin_d;
      llose_q     <= llose_d;
    end
  end

  assign state          = state_q;
  assign hit_count      = hit_q;
  assign miss_count     = miss_q;
  assign timer_start    = tstart_q;
  assign timer_miss     = tmiss_q;
  assign timer_game_end = tend_q;
  assign led_win        = lwin_q;
  assign led_lose       = llose_q;
endmodule
